// File: rtl/enc8x3_if.sv
// Handshake bundle for the sequential 8-to-3 encoder:
// capture request in, one index per accepted transfer out.
interface enc8x3_if;
    logic       start;
    logic [7:0] d;
    logic       out_ready;
    logic [2:0] q;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic       none;
    logic [3:0] count;

    modport master (
        output start, d, out_ready,
        input  q, out_valid, busy, done, none, count
    );

    modport slave (
        input  start, d, out_ready,
        output q, out_valid, busy, done, none, count
    );
endinterface

// File: rtl/enc8x3_seq.sv
// Sequential priority encoder: captures a word, then emits the index
// of each set bit, one per handshake, in the configured scan order.
module enc8x3_seq #(
    parameter int HIGH_FIRST = 1
) (
    input logic      clk,
    input logic      rst_n,
    enc8x3_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [3:0] count_q, count_d;
    logic       done_q, done_d;
    logic       none_q, none_d;
    logic [2:0] sel;
    logic [7:0] pend_clr;

    function automatic logic [2:0] pick(input logic [7:0] p);
        logic [2:0] r;
        r = 3'd0;
        if (HIGH_FIRST != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (p[i]) r = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (p[i]) r = 3'(i);
            end
        end
        return r;
    endfunction

    assign sel      = pick(pend_q);
    assign pend_clr = pend_q & ~(8'd1 << sel);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        count_d = count_q;
        done_d  = 1'b0;
        none_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pend_d  = bus.d;
                    count_d = 4'd0;
                    if (bus.d == 8'd0) begin
                        none_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    pend_d  = pend_clr;
                    count_d = count_q + 4'd1;
                    // Last pending bit accepted: finish on this same edge
                    if (pend_clr == 8'd0) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 8'd0;
            count_q <= 4'd0;
            done_q  <= 1'b0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            done_q  <= done_d;
            none_q  <= none_d;
        end
    end

    assign bus.out_valid = (state_q == EMIT);
    assign bus.q         = (state_q == EMIT) ? sel : 3'd0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.none      = none_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_enc8x3_seq.sv
// Drives both scan orders with the same stimulus and compares each
// against an index queue built directly from the captured word.
module tb_enc8x3_seq;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    enc8x3_if ifh ();
    enc8x3_if ifl ();

    enc8x3_seq #(.HIGH_FIRST(1)) u_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifh.slave)
    );

    enc8x3_seq #(.HIGH_FIRST(0)) u_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifl.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pk(
        input bit v, input bit b, input bit dn, input bit nn,
        input int c, input int qv
    );
        return {5'b0, v, b, dn, nn, 4'(c), 3'(qv)};
    endfunction

    function automatic logic [15:0] obs_hi();
        return {5'b0, ifh.out_valid, ifh.busy, ifh.done,
                ifh.none, ifh.count, ifh.q};
    endfunction

    function automatic logic [15:0] obs_lo();
        return {5'b0, ifl.out_valid, ifl.busy, ifl.done,
                ifl.none, ifl.count, ifl.q};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic [7:0] dv, input bit r);
        ifh.start = s;  ifl.start = s;
        ifh.d = dv;     ifl.d = dv;
        ifh.out_ready = r;
        ifl.out_ready = r;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low 3 cycles
    task automatic run_word(input logic [7:0] dv, input int mode,
                            input bit poke, input string tag);
        int qh[$];
        int ql[$];
        int emitted;
        int cyc;
        bit r;
        for (int i = 7; i >= 0; i--) if (dv[i]) qh.push_back(i);
        for (int i = 0; i < 8; i++) if (dv[i]) ql.push_back(i);
        emitted = 0;
        cyc = 0;
        drive(1'b1, dv, 1'b0);
        @(posedge clk); #1;
        while (qh.size() > 0 && cyc < 64) begin
            if (mode == 0) r = 1'b1;
            else if (mode == 2) r = (cyc >= 3);
            else r = 1'($urandom % 2);
            drive(poke ? 1'($urandom % 2) : 1'b0, 8'($urandom), r);
            #1;
            chk({tag, "_emit_hi"}, obs_hi(), pk(1, 1, 0, 0, emitted, qh[0]));
            chk({tag, "_emit_lo"}, obs_lo(), pk(1, 1, 0, 0, emitted, ql[0]));
            @(posedge clk); #1;
            if (r) begin
                void'(qh.pop_front());
                void'(ql.pop_front());
                emitted++;
            end
            cyc++;
        end
        // start held high through DONE must not retrigger
        drive(1'b1, 8'($urandom), 1'b0);
        #1;
        chk({tag, "_done_hi"}, obs_hi(), pk(0, 1, 1, dv == 0, emitted, 0));
        chk({tag, "_done_lo"}, obs_lo(), pk(0, 1, 1, dv == 0, emitted, 0));
        @(posedge clk); #1;
        drive(1'b0, 8'd0, 1'b0);
        #1;
        chk({tag, "_idle_hi"}, obs_hi(), pk(0, 0, 0, 0, emitted, 0));
        chk({tag, "_idle_lo"}, obs_lo(), pk(0, 0, 0, 0, emitted, 0));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 1'b0);
        #3;
        chk("reset_hi", obs_hi(), pk(0, 0, 0, 0, 0, 0));
        chk("reset_lo", obs_lo(), pk(0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_nostart", obs_hi(), pk(0, 0, 0, 0, 0, 0));

        run_word(8'hA4, 0, 1'b0, "a4");
        run_word(8'h00, 0, 1'b0, "zero");
        run_word(8'h81, 2, 1'b1, "x81");
        run_word(8'hFF, 0, 1'b0, "ff");

        // reset in the middle of emitting 0xF0
        drive(1'b1, 8'hF0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 1'b1);
        #1;
        chk("f0_e0", obs_hi(), pk(1, 1, 0, 0, 0, 7));
        @(posedge clk); #1;
        chk("f0_e1", obs_hi(), pk(1, 1, 0, 0, 1, 6));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_hi", obs_hi(), pk(0, 0, 0, 0, 0, 0));
        chk("async_rst_lo", obs_lo(), pk(0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        @(posedge clk); #1;
        chk("post_rst_idle", obs_hi(), pk(0, 0, 0, 0, 0, 0));
        run_word(8'h01, 0, 1'b0, "x01");

        for (int k = 0; k < 30; k++) begin
            logic [7:0] w;
            w = (k % 7 == 3) ? 8'h00 : 8'($urandom);
            run_word(w, 1, 1'b1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/enc8x3_seq.md
ENC8X3_SEQ -- requirements
Module: enc8x3_seq

Interface
REQ-001 SHALL provide parameter HIGH_FIRST, default 1, scan order: 1 = highest set index first, 0 = lowest set index first.
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port start  input  1  request to capture d; honoured only in IDLE.
REQ-005 SHALL provide port d  input  8  word to encode; bit k set means index k is pending.
REQ-006 SHALL provide port out_ready  input  1  consumer accepts current q when high with out_valid.
REQ-007 SHALL provide port q  output  3  encoded index of the currently selected pending bit.
REQ-008 SHALL provide port out_valid  output  1  q is valid and offered.
REQ-009 SHALL provide port busy  output  1  high in EMIT and DONE states.
REQ-010 SHALL provide port done  output  1  one-cycle pulse at end of each captured word.
REQ-011 SHALL provide port none  output  1  high with done when the captured word was zero.
REQ-012 SHALL provide port count  output  4  number of indices emitted for the current/last word (0..8).

Function
REQ-013 SHALL implement states IDLE, EMIT, DONE in a registered state machine.
REQ-014 IDLE, start=1, d!=0: SHALL on the edge load pend<=d, count<=0, go to EMIT.
REQ-015 IDLE, start=1, d==0: SHALL load pend<=0, count<=0, set none<=1, go to DONE.
REQ-016 start SHALL be ignored in EMIT and DONE; d changes after capture SHALL have no effect.
REQ-017 In EMIT, out_valid SHALL be 1 and q SHALL be the highest set index of pend (HIGH_FIRST=1) or lowest (HIGH_FIRST=0), combinational from registered pend (zero-cycle latency after capture edge).
REQ-018 Outside EMIT, out_valid SHALL be 0 and q SHALL be 3'b000.
REQ-019 q SHALL stay stable while out_valid=1 and out_ready=0 (no drop, no advance).
REQ-020 On each edge with out_valid=1 and out_ready=1: SHALL clear the selected bit in pend and increment count by 1.
REQ-021 If that clear leaves pend==0, SHALL go to DONE on the same edge; otherwise remain in EMIT with next index offered next cycle.
REQ-022 One transfer per cycle maximum; a word with N set bits SHALL take exactly N handshake cycles in EMIT.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE; none SHALL be 1 in DONE only for zero words, else 0.
REQ-024 start asserted in the DONE cycle SHALL be ignored; earliest new capture is the first IDLE cycle.
REQ-025 count SHALL hold its final value in IDLE until the next accepted start; count SHALL never exceed 8.
REQ-026 d=8'hFF SHALL yield 8 emissions, count=8, no wrap of count.

Reset
REQ-027 rst_n=0 SHALL immediately, without clock: state=IDLE, pend=0, count=0, q=0, out_valid=0, busy=0, done=0, none=0.
REQ-028 Reset mid-EMIT SHALL discard remaining pending bits with no done pulse; after release, block waits in IDLE for start.
REQ-029 First capture after reset release SHALL require one rising edge with rst_n=1 and start=1.

Verification
REQ-030 HIGH_FIRST=1, start with d=8'b1010_0100, out_ready=1 -> q=7,5,2 on three consecutive cycles, then done=1, none=0, count=3.
REQ-031 HIGH_FIRST=0, same d, out_ready=1 -> q=2,5,7, then done=1, count=3.
REQ-032 d=8'h00 start -> next cycle done=1, none=1, out_valid never 1, count=0.
REQ-033 d=8'h81, out_ready low 3 cycles then high -> q=7 held 3 cycles, then q=7 accepted, q=0, done; start pulsed during EMIT ignored.
REQ-034 d=8'hFF, out_ready=1 -> 8 emissions 7..0, count=8, done one cycle, busy low afterward.
REQ-035 rst_n pulled low after 2 emissions of 8'hF0 -> all outputs 0 asynchronously, no done, next start with d=8'h01 -> q=0, count=1.
